// File: rtl/conv_seq_pkg.sv
// Shared types and sizing helpers for the convolver sequencer.
package conv_seq_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_WREQ  = 3'd1,
      ST_WLAT  = 3'd2,
      ST_CLR   = 3'd3,
      ST_RUN   = 3'd4,
      ST_NEXT  = 3'd5,
      ST_FLUSH = 3'd6,
      ST_DONE  = 3'd7
   } state_e;

   function automatic int filt_w(input int max_filt);
      return $clog2(max_filt + 1);
   endfunction

   function automatic int opf_calc(input int n, input int k, input int s);
      return ((n - k) / s + 1) * ((n - k) / s + 1);
   endfunction

   function automatic int wword_w(input int k, input int dw);
      return k * k * dw;
   endfunction

   localparam int WWORD_W_DEFAULT = wword_w(3, 16);

endpackage

// File: rtl/conv_seq_fifo.sv
// Synchronous result FIFO holding {filter tag, result} entries; cleared on reset.
module conv_seq_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 34
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  logic [WIDTH-1:0]           push_data,
   input  logic                       pop,
   output logic [WIDTH-1:0]           pop_data,
   output logic [$clog2(DEPTH+1)-1:0] count
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             push_ok_s, pop_ok_s;

   // next-state for storage, pointers and occupancy
   always_comb begin
      push_ok_s = push && (cnt_q != CW'(DEPTH));
      pop_ok_s  = pop && (cnt_q != '0);
      mem_d     = mem_q;
      if (push_ok_s) begin
         mem_d[wr_ptr_q] = push_data;
         wr_ptr_d        = wr_ptr_q + PW'(1'b1);
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
      if (pop_ok_s) begin
         rd_ptr_d = rd_ptr_q + PW'(1'b1);
      end else begin
         rd_ptr_d = rd_ptr_q;
      end
      case ({push_ok_s, pop_ok_s})
         2'b10:   cnt_d = cnt_q + CW'(1'b1);
         2'b01:   cnt_d = cnt_q - CW'(1'b1);
         default: cnt_d = cnt_q;
      endcase
   end

   // state registers
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   assign pop_data = mem_q[rd_ptr_q];
   assign count    = cnt_q;

endmodule

// File: rtl/conv_sequencer.sv
// Control sequencer for one convolver: weight fetch, clear, activation streaming, tagged results.
// Build option CONV_SEQ_RELU_EN clamps negative (signed) convolver results to zero.
module conv_sequencer import conv_seq_pkg::*; #(
   parameter int N          = 4,
   parameter int K          = 3,
   parameter int S          = 1,
   parameter int DW         = 16,
   parameter int OW         = 32,
   parameter int MAX_FILT   = 4,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                           clk,
   input  logic                           global_rst,
   input  logic                           start,
   input  logic [filt_w(MAX_FILT)-1:0]    num_filt,
   output logic                           busy,
   output logic                           done,
   output logic                           err,
   output logic [filt_w(MAX_FILT)-2:0]    w_addr,
   input  logic [K*K*DW-1:0]              w_data,
   input  logic [DW-1:0]                  s_act_data,
   input  logic                           s_act_valid,
   output logic                           s_act_ready,
   output logic                           conv_ce,
   output logic                           conv_rst,
   output logic [K*K*DW-1:0]              conv_weight,
   output logic [DW-1:0]                  conv_act,
   input  logic [OW-1:0]                  conv_op,
   input  logic                           conv_valid,
   input  logic                           conv_end,
   output logic [OW-1:0]                  m_res_data,
   output logic [filt_w(MAX_FILT)-2:0]    m_res_filt,
   output logic                           m_res_valid,
   input  logic                           m_res_ready
);
   localparam int FW  = filt_w(MAX_FILT);
   localparam int TW  = FW - 1;
   localparam int WW  = wword_w(K, DW);
   localparam int NN  = N * N;
   localparam int CW  = $clog2(NN + 1);
   localparam int OPF = opf_calc(N, K, S);
   localparam int QW  = $clog2(FIFO_DEPTH + 1);
   localparam int EW  = TW + OW;

   state_e          state_q, state_d;
   logic [FW-1:0]   num_filt_q, num_filt_d, filt_idx_q, filt_idx_d;
   logic [CW-1:0]   act_cnt_q, act_cnt_d, res_cnt_q, res_cnt_d;
   logic [WW-1:0]   weight_q, weight_d;
   logic [TW-1:0]   w_addr_q, w_addr_d;
   logic            busy_q, busy_d, done_q, done_d, err_q, err_d;

   logic [FW-1:0]   nf_clamped_s;
   logic            act_ready_s, ce_s, push_s, pop_s;
   logic [OW-1:0]   res_data_s;
   logic [QW-1:0]   fifo_cnt_s;
   logic [EW-1:0]   fifo_out_s;

   assign nf_clamped_s = (num_filt > FW'(MAX_FILT)) ? FW'(MAX_FILT) : num_filt;
   // a free FIFO slot is guaranteed before every ce, so the convolver never loses a result
   assign act_ready_s  = (state_q == ST_RUN) && (act_cnt_q < CW'(NN)) && (fifo_cnt_s < QW'(FIFO_DEPTH));
   assign ce_s         = s_act_valid && act_ready_s;
   assign push_s       = conv_valid && ce_s;
   assign pop_s        = (fifo_cnt_s != '0) && m_res_ready;

   // result shaping before the FIFO
   always_comb begin
`ifdef CONV_SEQ_RELU_EN
      if (conv_op[OW-1]) begin
         res_data_s = '0;
      end else begin
         res_data_s = conv_op;
      end
`else
      res_data_s = conv_op;
`endif
   end

   // sequencer next-state and registered-output computation
   always_comb begin
      state_d    = state_q;
      num_filt_d = num_filt_q;
      filt_idx_d = filt_idx_q;
      act_cnt_d  = act_cnt_q;
      res_cnt_d  = res_cnt_q;
      weight_d   = weight_q;
      err_d      = err_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               num_filt_d = nf_clamped_s;
               filt_idx_d = '0;
               if (nf_clamped_s != '0) begin
                  state_d = ST_WREQ;
               end else begin
                  state_d = ST_DONE;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_WREQ: state_d = ST_WLAT;
         ST_WLAT: begin
            weight_d = w_data;
            state_d  = ST_CLR;
         end
         ST_CLR: begin
            act_cnt_d = '0;
            res_cnt_d = '0;
            state_d   = ST_RUN;
         end
         ST_RUN: begin
            act_cnt_d = act_cnt_q + CW'(ce_s);
            if (res_cnt_q != CW'(OPF)) begin
               res_cnt_d = res_cnt_q + CW'(push_s);
            end else begin
               res_cnt_d = res_cnt_q;
            end
            if (conv_end && ce_s && ((res_cnt_q + CW'(push_s)) != CW'(OPF))) begin
               err_d = 1'b1;
            end else begin
               err_d = err_q;
            end
            if (act_cnt_q == CW'(NN)) begin
               state_d = ST_NEXT;
            end else begin
               state_d = ST_RUN;
            end
         end
         ST_NEXT: begin
            filt_idx_d = filt_idx_q + FW'(1'b1);
            if ((filt_idx_q + FW'(1'b1)) < num_filt_q) begin
               state_d = ST_WREQ;
            end else begin
               state_d = ST_FLUSH;
            end
         end
         ST_FLUSH: begin
            if (fifo_cnt_s == '0) begin
               state_d = ST_DONE;
            end else begin
               state_d = ST_FLUSH;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
      busy_d   = (state_d != ST_IDLE) && (state_d != ST_DONE);
      done_d   = (state_d == ST_DONE);
      w_addr_d = filt_idx_d[TW-1:0];
   end

   // sequencer registers
   always_ff @(posedge clk) begin
      if (global_rst) begin
         state_q    <= ST_IDLE;
         num_filt_q <= '0;
         filt_idx_q <= '0;
         act_cnt_q  <= '0;
         res_cnt_q  <= '0;
         weight_q   <= '0;
         w_addr_q   <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         num_filt_q <= num_filt_d;
         filt_idx_q <= filt_idx_d;
         act_cnt_q  <= act_cnt_d;
         res_cnt_q  <= res_cnt_d;
         weight_q   <= weight_d;
         w_addr_q   <= w_addr_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         err_q      <= err_d;
      end
   end

   conv_seq_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (EW)
   ) u_fifo (
      .clk       (clk),
      .rst       (global_rst),
      .push      (push_s),
      .push_data ({filt_idx_q[TW-1:0], res_data_s}),
      .pop       (pop_s),
      .pop_data  (fifo_out_s),
      .count     (fifo_cnt_s)
   );

   assign busy        = busy_q;
   assign done        = done_q;
   assign err         = err_q;
   assign w_addr      = w_addr_q;
   assign s_act_ready = act_ready_s;
   assign conv_ce     = ce_s;
   assign conv_rst    = global_rst || (state_q == ST_CLR);
   assign conv_weight = weight_q;
   assign conv_act    = s_act_data;
   assign m_res_data  = fifo_out_s[OW-1:0];
   assign m_res_filt  = fifo_out_s[EW-1:OW];
   assign m_res_valid = (fifo_cnt_s != '0);

endmodule

// File: tb/tb_conv_sequencer.sv
// Scoreboard bench for conv_sequencer with behavioural weight bank and convolver models.
module tb_conv_sequencer;
   localparam int N  = 4;
   localparam int K  = 3;
   localparam int DW = 16;
   localparam int OW = 32;
   localparam int FW = 3;
   localparam int TW = 2;
   localparam int WW = K * K * DW;
   localparam int NN = N * N;

   logic          clk;
   logic          global_rst, start, busy, done, err;
   logic [FW-1:0] num_filt;
   logic [TW-1:0] w_addr, m_res_filt;
   logic [WW-1:0] w_data, conv_weight;
   logic [DW-1:0] s_act_data, conv_act;
   logic          s_act_valid, s_act_ready, conv_ce, conv_rst;
   logic [OW-1:0] conv_op, m_res_data;
   logic          conv_valid, conv_end, m_res_valid, m_res_ready;

   conv_sequencer #(.FIFO_DEPTH(2)) dut (
      .clk(clk), .global_rst(global_rst), .start(start), .num_filt(num_filt),
      .busy(busy), .done(done), .err(err), .w_addr(w_addr), .w_data(w_data),
      .s_act_data(s_act_data), .s_act_valid(s_act_valid), .s_act_ready(s_act_ready),
      .conv_ce(conv_ce), .conv_rst(conv_rst), .conv_weight(conv_weight), .conv_act(conv_act),
      .conv_op(conv_op), .conv_valid(conv_valid), .conv_end(conv_end),
      .m_res_data(m_res_data), .m_res_filt(m_res_filt), .m_res_valid(m_res_valid),
      .m_res_ready(m_res_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks, errors;
   int ce_cnt, rstp_cnt, done_cnt;
   logic conv_rst_prev, done_prev;
   logic [TW+OW-1:0] exp_q [$];
   logic [TW+OW-1:0] mon_exp;
   int exp_raw [4][4] = '{'{375236, 418352, 547700, 590816},
                          '{10, 11, 14, 15},
                          '{0, 2, 8, 10},
                          '{-10, -6, 6, 10}};

   // weight bank: registered read, data one cycle after address
   logic [WW-1:0] bank [4];
   always @(posedge clk) w_data <= bank[w_addr];

   // convolver model: raster-order KxK window, result valid in the ce cycle completing a window
   logic [DW-1:0] abuf [NN];
   int cv_cnt, cv_acc, cv_idx;
   logic [DW-1:0] cv_a;
   logic end_early;
   always @(posedge clk) begin
      if (conv_rst) cv_cnt <= 0;
      else if (conv_ce) begin
         abuf[cv_cnt[3:0]] <= conv_act;
         cv_cnt <= cv_cnt + 1;
      end
   end
   always_comb begin
      cv_acc = 0;
      cv_idx = 0;
      cv_a = '0;
      conv_valid = 1'b0;
      if (cv_cnt < NN && (cv_cnt / N) >= K - 1 && (cv_cnt % N) >= K - 1) begin
         conv_valid = 1'b1;
         for (int kr = 0; kr < K; kr++) begin
            for (int kc = 0; kc < K; kc++) begin
               cv_idx = (cv_cnt / N - (K - 1) + kr) * N + (cv_cnt % N - (K - 1) + kc);
               cv_a = (cv_idx == cv_cnt) ? conv_act : abuf[cv_idx[3:0]];
               cv_acc = cv_acc + int'($signed(conv_weight[(kr*K+kc)*DW +: DW])) * int'(cv_a);
            end
         end
      end
      conv_op = cv_acc;
      conv_end = end_early ? (cv_cnt == NN - 2) : (cv_cnt == NN - 1);
   end

   // activation source: values 0..15 repeating, advancing on each accepted activation
   logic [3:0] src_idx;
   logic ce_seen;
   initial begin : source
      forever begin
         @(negedge clk);
         ce_seen = conv_ce;
         @(posedge clk);
         #1;
         if (ce_seen) src_idx = src_idx + 4'd1;
         s_act_data = {12'h000, src_idx};
      end
   end

   // monitor: event counters and scoreboard pops
   initial begin : monitor
      conv_rst_prev = 1'b1;
      done_prev = 1'b0;
      forever begin
         @(negedge clk);
         if (conv_ce) ce_cnt++;
         if (conv_rst && !conv_rst_prev && !global_rst) rstp_cnt++;
         conv_rst_prev = conv_rst;
         if (done) begin
            checks++;
            if (done_prev) begin
               errors++;
               $display("FAIL done_width actual=2+ cycles required=1 cycle");
            end
            done_cnt++;
         end
         done_prev = done;
         if (m_res_valid && m_res_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL result_extra actual filt=%0d data=%0h required=none", m_res_filt, m_res_data);
            end else begin
               mon_exp = exp_q.pop_front();
               if ({m_res_filt, m_res_data} !== mon_exp) begin
                  errors++;
                  $display("FAIL result actual filt=%0d data=%0h required filt=%0d data=%0h",
                           m_res_filt, m_res_data, mon_exp[TW+OW-1:OW], mon_exp[OW-1:0]);
               end
            end
         end
      end
   end

   task automatic chk(input string name, input int act, input int expv);
      checks++;
      if (act != expv) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", name, act, expv);
      end
   endtask

   task automatic push_exp(input int f);
      logic [OW-1:0] v;
      for (int i = 0; i < 4; i++) begin
         v = exp_raw[f][i];
`ifdef CONV_SEQ_RELU_EN
         if (v[OW-1]) v = '0;
`endif
         exp_q.push_back({f[TW-1:0], v});
      end
   endtask

   task automatic run_job(input logic [FW-1:0] nf, input int nf_eff, input bit hold);
      int ce0, rp0, d0, n;
      ce0 = ce_cnt;
      rp0 = rstp_cnt;
      d0 = done_cnt;
      for (int f = 0; f < nf_eff; f++) push_exp(f);
      @(posedge clk);
      #1;
      start = 1'b1;
      num_filt = nf;
      if (hold) m_res_ready = 1'b0;
      @(posedge clk);
      #1;
      start = 1'b0;
      @(negedge clk);
      chk("busy_after_start", int'(busy), (nf_eff != 0) ? 1 : 0);
      if (hold) begin
         repeat (40) @(negedge clk);
         chk("stall_ce_count", ce_cnt - ce0, 12);
         chk("stall_act_ready", int'(s_act_ready), 0);
         chk("stall_res_valid", int'(m_res_valid), 1);
         @(posedge clk);
         #1;
         m_res_ready = 1'b1;
      end
      n = 0;
      while (done_cnt == d0 && n < 400) begin
         @(posedge clk);
         n++;
      end
      chk("job_done_seen", (done_cnt != d0) ? 1 : 0, 1);
      if (nf_eff == 0) chk("zero_job_done_latency_ok", (n <= 2) ? 1 : 0, 1);
      chk("ce_count", ce_cnt - ce0, 16 * nf_eff);
      chk("clr_pulses", rstp_cnt - rp0, nf_eff);
      @(negedge clk);
      chk("busy_after_done", int'(busy), 0);
      chk("queue_drained", exp_q.size(), 0);
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1);
   end

   initial begin : main
      int ce0, n;
      checks = 0; errors = 0; ce_cnt = 0; rstp_cnt = 0; done_cnt = 0;
      global_rst = 1'b1; start = 1'b0; num_filt = 3'd0;
      s_act_valid = 1'b0; s_act_data = 16'h0000; src_idx = 4'd0;
      m_res_ready = 1'b1; end_early = 1'b0;
      bank[0] = {16'h0008, 16'h7654, 16'h3210, 96'h0};
      bank[1] = {16'h0001, 128'h0};
      bank[2] = {128'h0, 16'h0002};
      bank[3] = {16'hFFFF, 112'h0, 16'h0005};

      // reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_res_valid", int'(m_res_valid), 0);
      chk("rst_act_ready", int'(s_act_ready), 0);
      chk("rst_conv_rst", int'(conv_rst), 1);
      chk("rst_err", int'(err), 0);
      @(posedge clk);
      #1;
      global_rst = 1'b0;
      s_act_valid = 1'b1;

      run_job(3'd1, 1, 1'b0);      // single filter
      run_job(3'd3, 3, 1'b0);      // three filters, tags 0,1,2
      run_job(3'd1, 1, 1'b1);      // sink backpressure with 2-entry FIFO
      run_job(3'd0, 0, 1'b0);      // empty job
      chk("err_clean", int'(err), 0);

      // abort after the 7th activation, then rerun
      push_exp(0);
      @(posedge clk);
      #1;
      start = 1'b1;
      num_filt = 3'd1;
      @(posedge clk);
      #1;
      start = 1'b0;
      ce0 = ce_cnt;
      n = 0;
      while (ce_cnt - ce0 < 7 && n < 100) begin
         @(posedge clk);
         n++;
      end
      chk("abort_reached_7", (ce_cnt - ce0 >= 7) ? 1 : 0, 1);
      #1;
      global_rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("abort_busy", int'(busy), 0);
      chk("abort_res_valid", int'(m_res_valid), 0);
      chk("abort_act_ready", int'(s_act_ready), 0);
      exp_q.delete();
      src_idx = 4'd0;
      s_act_data = 16'h0000;
      @(posedge clk);
      #1;
      global_rst = 1'b0;
      run_job(3'd1, 1, 1'b0);

      run_job(3'd7, 4, 1'b0);      // clamps to 4 filters, includes negative results

      // conv_end arriving with a short result count
      end_early = 1'b1;
      run_job(3'd1, 1, 1'b0);
      chk("err_set", int'(err), 1);
      end_early = 1'b0;
      @(posedge clk);
      #1;
      global_rst = 1'b1;
      @(posedge clk);
      #1;
      global_rst = 1'b0;
      @(negedge clk);
      chk("err_cleared_by_reset", int'(err), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
